// File: rtl/seg7_scan_decoder_if.sv
// Display-bus interface for seg7_scan_decoder.
// The master side drives the multiplexed display lines (digit selects and
// segments); the slave side (the decoder) returns the reconstructed digits.
// Optional macro SEG7_SCAN_DP_EN adds the per-digit decimal-point result dp_out.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   sel_n;        // digit selects, active low
    logic [7:0]          seg;          // bit7 = dp, bits6..0 = g..a, active low
    logic [4*DIGITS-1:0] bcd_out;      // digit i at [4i+3:4i]
    logic [DIGITS-1:0]   err;          // last capture of digit i was not 0..9
    logic                frame_valid;  // one-cycle publish strobe
`ifdef SEG7_SCAN_DP_EN
    logic [DIGITS-1:0]   dp_out;       // decimal point lit for digit i

    modport master (output sel_n, seg, input bcd_out, err, frame_valid, dp_out);
    modport slave  (input sel_n, seg, output bcd_out, err, frame_valid, dp_out);
`else
    modport master (output sel_n, seg, input bcd_out, err, frame_valid);
    modport slave  (input sel_n, seg, output bcd_out, err, frame_valid);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: observes a multiplexed common-anode (active-low) 7-segment
// bus and reconstructs the BCD value of every digit. A pattern is captured
// once per select period after it has been stable for SETTLE synchronised
// cycles; all digits are published together when every digit has been seen.
// Optional macro SEG7_SCAN_DP_EN: also capture and publish the decimal points.
module seg7_scan_decoder #(
    parameter int DIGITS = 4,   // 2..8
    parameter int SETTLE = 4    // 1..255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_decoder_if.slave   bus
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    // Segment pattern (g..a, active low) to BCD; anything else is 4'hF.
    function automatic logic [3:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   return 4'd0;
            7'h79:   return 4'd1;
            7'h24:   return 4'd2;
            7'h30:   return 4'd3;
            7'h19:   return 4'd4;
            7'h12:   return 4'd5;
            7'h02:   return 4'd6;
            7'h78:   return 4'd7;
            7'h00:   return 4'd8;
            7'h10:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    logic [DIGITS-1:0]   r_sel_m, r_sel_s, r_sel_p;
    logic [7:0]          r_seg_m, r_seg_s, r_seg_p;
    logic [7:0]          r_cnt;
    state_t              r_state, w_next;
    logic [DIGITS-1:0]   r_mask;
    logic [4*DIGITS-1:0] r_shadow_bcd;
    logic [DIGITS-1:0]   r_shadow_err;
    logic [4*DIGITS-1:0] r_bcd_out;
    logic [DIGITS-1:0]   r_err;
    logic                r_frame_valid;

    logic [DIGITS-1:0]   w_sel_low;
    logic                w_valid;
    logic                w_stable;
    logic                w_hold_ok;
    logic                w_capture;
    logic [DIGITS-1:0]   w_cap_bits;
    logic                w_full;
    logic [3:0]          w_dec;

    // Two-flop synchronisers, then one more stage to detect changes.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_m <= '1;
            r_sel_s <= '1;
            r_sel_p <= '1;
            r_seg_m <= '1;
            r_seg_s <= '1;
            r_seg_p <= '1;
        end else begin
            r_sel_m <= bus.sel_n;
            r_sel_s <= r_sel_m;
            r_sel_p <= r_sel_s;
            r_seg_m <= bus.seg;
            r_seg_s <= r_seg_m;
            r_seg_p <= r_seg_s;
        end
    end

    // Exactly one select low; any change on any segment line (dp included)
    // restarts the settle window.
    assign w_sel_low = ~r_sel_s;
    assign w_valid   = (w_sel_low != '0) && ((w_sel_low & (w_sel_low - DIGITS'(1))) == '0);
    assign w_stable  = (r_sel_s == r_sel_p) && (r_seg_s == r_seg_p);
    assign w_hold_ok = w_valid && w_stable;

    // Settle counter: counts stable valid cycles, saturates at SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_hold_ok) begin
            if (r_cnt != SETTLE_C) r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state: CAPTURE is entered on the edge where cnt reaches SETTLE;
    // the >= also covers a counter that saturated before SETTLE was entered.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_valid) w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (!w_valid)                           w_next = ST_IDLE;
                else if (w_stable && r_cnt >= SETTLE_M1) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: w_next = ST_HOLD;
            ST_HOLD:    if (!w_hold_ok) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // FSM outputs. During CAPTURE the p stage holds the values that were
    // qualified, even if the s stage has already moved on.
    always_comb begin
        w_capture  = (r_state == ST_CAPTURE);
        w_cap_bits = w_capture ? ~r_sel_p : '0;
    end

    assign w_dec  = f_decode(r_seg_p[6:0]);
    assign w_full = &r_mask;

    // Shadow slots and capture mask; a repeated digit just overwrites its slot.
    // NOTE: the shadow slots are reset like every other flop, so a reset
    // mid-frame can never leak stale digits into the next published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_bcd <= '0;
            r_shadow_err <= '0;
            r_mask       <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_cap_bits[i]) begin
                    r_shadow_bcd[4*i +: 4] <= w_dec;
                    r_shadow_err[i]        <= (w_dec == 4'hF);
                end
            end
            r_mask <= w_full ? w_cap_bits : (r_mask | w_cap_bits);
        end
    end

    // Publish the whole frame in one cycle when the mask is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_out     <= '0;
            r_err         <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_full;
            if (w_full) begin
                r_bcd_out <= r_shadow_bcd;
                r_err     <= r_shadow_err;
            end
        end
    end

    assign bus.bcd_out     = r_bcd_out;
    assign bus.err         = r_err;
    assign bus.frame_valid = r_frame_valid;

`ifdef SEG7_SCAN_DP_EN
    logic [DIGITS-1:0] r_shadow_dp;
    logic [DIGITS-1:0] r_dp_out;

    // Decimal points ride along with the digits: captured and published together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_dp <= '0;
            r_dp_out    <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_cap_bits[i]) r_shadow_dp[i] <= ~r_seg_p[7];
            end
            if (w_full) r_dp_out <= r_shadow_dp;
        end
    end

    assign bus.dp_out = r_dp_out;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (DIGITS=4, SETTLE=4).
// Active-low patterns (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
// Build with +define+SEG7_SCAN_DP_EN to also exercise dp_out.
module tb_seg7_scan_decoder;

    logic clk;
    logic rst_n;

    seg7_scan_decoder_if #(.DIGITS(4)) bus ();

    seg7_scan_decoder #(.DIGITS(4), .SETTLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame monitor: counts publish pulses and back-to-back pulses.
    int          fv_count  = 0;
    int          fv_double = 0;
    logic        fv_prev   = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.frame_valid) begin
            fv_count++;
            if (fv_prev) fv_double++;
        end
        fv_prev = bus.frame_valid;
    end

    // Drive one select/segment pair for a number of cycles (returns at negedge).
    task automatic show(input logic [3:0] sel, input logic [7:0] sg, input int cycles);
        bus.sel_n = sel;
        bus.seg   = sg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        if (bus.bcd_out !== 16'h0000) $display("FAIL reset_bcd got=%h exp=0000", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.err !== 4'b0000) $display("FAIL reset_err got=%b exp=0000", bus.err);
        else n_pass++;
        n_checks++;
        if (bus.frame_valid !== 1'b0) $display("FAIL reset_fv got=%b exp=0", bus.frame_valid);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_scan();
        int base;
        base = fv_count;
        show(4'b1110, 8'hC0, 10);
        show(4'b1101, 8'hF9, 10);
        show(4'b1011, 8'hA4, 10);
        // Three digits captured: nothing may be published yet.
        if (fv_count - base !== 0) $display("FAIL scan_partial_fv got=%0d exp=0", fv_count - base);
        else n_pass++;
        n_checks++;
        if (bus.bcd_out !== 16'h0000) $display("FAIL scan_partial_bcd got=%h exp=0000", bus.bcd_out);
        else n_pass++;
        n_checks++;
        show(4'b0111, 8'hB0, 10);
        show(4'b1111, 8'hFF, 5);
        if (fv_count - base !== 1) $display("FAIL scan_fv_count got=%0d exp=1", fv_count - base);
        else n_pass++;
        n_checks++;
        if (bus.bcd_out !== 16'h3210) $display("FAIL scan_bcd got=%h exp=3210", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.err !== 4'b0000) $display("FAIL scan_err got=%b exp=0000", bus.err);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_unstable();
        int base;
        int k;
        base = fv_count;
        show(4'b1110, 8'h92, 10);
        show(4'b1101, 8'h82, 10);
        show(4'b1011, 8'hF8, 10);
        // Segments change every 3 cycles: the counter never reaches SETTLE.
        for (int t = 0; t < 8; t++) show(4'b0111, (t % 2 == 0) ? 8'h90 : 8'h99, 3);
        if (fv_count - base !== 0) $display("FAIL unstable_no_frame got=%0d exp=0", fv_count - base);
        else n_pass++;
        n_checks++;
        // Hold '8': 2 sync + 1 compare + 3 counts -> CAPTURE on edge 7,
        // mask full on edge 8, frame_valid after edge 9.
        bus.seg = 8'h80;
        k = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) begin
                k = c;
                break;
            end
        end
        if (k !== 9) $display("FAIL unstable_latency got=%0d exp=9 cycles", k);
        else n_pass++;
        n_checks++;
        show(4'b1111, 8'hFF, 5);
        if (bus.bcd_out !== 16'h8765) $display("FAIL unstable_bcd got=%h exp=8765", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (fv_count - base !== 1) $display("FAIL unstable_fv_count got=%0d exp=1", fv_count - base);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_invalid_pattern();
        show(4'b1110, 8'hC0, 10);
        show(4'b1101, 8'hF9, 10);
        show(4'b1011, 8'hFF, 10);
        show(4'b0111, 8'hB0, 10);
        show(4'b1111, 8'hFF, 5);
        if (bus.bcd_out !== 16'h3F10) $display("FAIL badpat_bcd got=%h exp=3f10", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.err !== 4'b0100) $display("FAIL badpat_err got=%b exp=0100", bus.err);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_gaps_glitch();
        int base;
        base = fv_count;
        show(4'b1110, 8'hC0, 10);
        show(4'b1111, 8'hF8, 4);
        show(4'b1101, 8'h99, 10);
        // Two selects low for a long time: never a valid select, never captured.
        show(4'b1100, 8'hF8, 10);
        show(4'b1011, 8'h92, 10);
        show(4'b1111, 8'hF8, 6);
        show(4'b0111, 8'h82, 10);
        show(4'b1111, 8'hFF, 5);
        if (fv_count - base !== 1) $display("FAIL gaps_fv_count got=%0d exp=1", fv_count - base);
        else n_pass++;
        n_checks++;
        if (bus.bcd_out !== 16'h6540) $display("FAIL gaps_bcd got=%h exp=6540", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.err !== 4'b0000) $display("FAIL gaps_err got=%b exp=0000", bus.err);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        show(4'b1110, 8'hC0, 10);
        show(4'b1101, 8'hF9, 10);
        bus.sel_n = 4'b1111;
        bus.seg   = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (bus.bcd_out !== 16'h0000) $display("FAIL midrst_bcd got=%h exp=0000", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.err !== 4'b0000) $display("FAIL midrst_err got=%b exp=0000", bus.err);
        else n_pass++;
        n_checks++;
        rst_n = 1'b1;
        base = fv_count;
        show(4'b1111, 8'hFF, 3);
        show(4'b1011, 8'hA4, 10);
        show(4'b0111, 8'hB0, 10);
        show(4'b1111, 8'hFF, 5);
        if (fv_count - base !== 0) $display("FAIL midrst_no_partial got=%0d exp=0", fv_count - base);
        else n_pass++;
        n_checks++;
        show(4'b1110, 8'hC0, 10);
        show(4'b1101, 8'hF9, 10);
        show(4'b1111, 8'hFF, 5);
        if (fv_count - base !== 1) $display("FAIL midrst_fv_count got=%0d exp=1", fv_count - base);
        else n_pass++;
        n_checks++;
        if (bus.bcd_out !== 16'h3210) $display("FAIL midrst_bcd_after got=%h exp=3210", bus.bcd_out);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int base;
        base = fv_count;
        show(4'b1110, 8'h90, 10);
        show(4'b1101, 8'h80, 10);
        show(4'b1011, 8'hF8, 10);
        show(4'b0111, 8'h82, 10);
        if (bus.bcd_out !== 16'h6789) $display("FAIL b2b_first_bcd got=%h exp=6789", bus.bcd_out);
        else n_pass++;
        n_checks++;
        show(4'b1110, 8'hF9, 10);
        show(4'b1101, 8'hA4, 10);
        show(4'b1011, 8'hB0, 10);
        show(4'b0111, 8'h99, 10);
        show(4'b1111, 8'hFF, 5);
        if (fv_count - base !== 2) $display("FAIL b2b_fv_count got=%0d exp=2", fv_count - base);
        else n_pass++;
        n_checks++;
        if (bus.bcd_out !== 16'h4321) $display("FAIL b2b_second_bcd got=%h exp=4321", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (fv_double !== 0) $display("FAIL fv_consecutive got=%0d exp=0", fv_double);
        else n_pass++;
        n_checks++;
    endtask

`ifdef SEG7_SCAN_DP_EN
    task automatic test_dp();
        show(4'b1110, 8'h40, 10);
        show(4'b1101, 8'hF9, 10);
        show(4'b1011, 8'hA4, 10);
        show(4'b0111, 8'hB0, 10);
        show(4'b1111, 8'hFF, 5);
        if (bus.bcd_out !== 16'h3210) $display("FAIL dp_bcd got=%h exp=3210", bus.bcd_out);
        else n_pass++;
        n_checks++;
        if (bus.dp_out !== 4'b0001) $display("FAIL dp_out got=%b exp=0001", bus.dp_out);
        else n_pass++;
        n_checks++;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        bus.sel_n = 4'b1111;
        bus.seg   = 8'hFF;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_scan();
        test_unstable();
        test_invalid_pattern();
        test_gaps_glitch();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SEG7_SCAN_DP_EN
        test_dp();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
